game_round_ctrl: RTL and testbench

- Sequencer for the seven-segment game timer datapath. Runs a fixed number of countdown rounds, generates the 1-second tick, and handles start/pause button edges.
- Keeps BCD seconds-remaining and BCD score, and presents them as four display nibbles for the existing digit mux/scan logic.
- Sits between the debounced buttons and the display path, replacing ad-hoc compare-and-increment logic with one registered FSM.

---
 rtl/game_round_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_game_round_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for the seven-segment game timer.
// Runs MAX_ROUNDS countdown rounds of ROUND_SECS seconds each and divides clk
// by TICK_DIV to produce the 1-second tick. It also edge-detects the start and
// pause buttons and keeps the BCD seconds and BCD score that feed the digit mux.
//
// Optional build macro: GAME_ROUND_AUTO_ADVANCE_EN
//   defined   - TIMEOUT goes straight to LOAD for the next round, so no GAP wait
//   undefined - GAP waits for a start rise before loading the next round
module game_round_ctrl #(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned ROUND_SECS = 10,
    parameter int unsigned MAX_ROUNDS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        hit,
    output logic [15:0] disp_val,
    output logic [3:0]  round,
    output logic [2:0]  state,
    output logic        tick,
    output logic        round_done,
    output logic        game_over
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int unsigned        PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [7:0]         SECS_INIT  = {4'(ROUND_SECS / 10), 4'(ROUND_SECS % 10)};
    localparam logic [3:0]         ROUND_LAST = 4'(MAX_ROUNDS);
    localparam logic [7:0]         SCORE_MAX  = 8'h99;

    // The encoding is visible on the state port, so it is fixed explicitly.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_PAUSE   = 3'd3,
        S_TIMEOUT = 3'd4,
        S_GAP     = 3'd5,
        S_OVER    = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             state_q,      state_d;
    logic [7:0]         secs_q,       secs_d;        // {tens, ones} BCD
    logic [7:0]         score_q,      score_d;       // {tens, ones} BCD
    logic [3:0]         round_q,      round_d;
    logic [PRESC_W-1:0] presc_q,      presc_d;
    logic               start_q,      start_d;       // previous start level
    logic               pause_q,      pause_d;       // previous pause level
    logic               tick_q,       tick_d;
    logic               round_done_q, round_done_d;
    logic               game_over_q,  game_over_d;

    logic start_rise;
    logic pause_rise;
    logic presc_last;
    logic final_tick;

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------
    // Two-digit BCD decrement; callers never pass 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    // Two-digit BCD increment that holds at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == SCORE_MAX) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Edge detect and tick qualifiers
    // ------------------------------------------------------------------
    assign start_rise = start & ~start_q;
    assign pause_rise = pause & ~pause_q;
    assign presc_last = (presc_q == PRESC_LAST);
    assign final_tick = presc_last && (secs_q == 8'h01);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // Hold the FSM state; synchronous reset to IDLE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking (<=) so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Hold the datapath and the registered output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            secs_q       <= SECS_INIT;
            score_q      <= 8'h00;
            round_q      <= 4'd1;
            presc_q      <= '0;
            // Held buttons must not look like a fresh press once rst drops.
            start_q      <= 1'b1;
            pause_q      <= 1'b1;
            tick_q       <= 1'b0;
            round_done_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            secs_q       <= secs_d;
            score_q      <= score_d;
            round_q      <= round_d;
            presc_q      <= presc_d;
            start_q      <= start_d;
            pause_q      <= pause_d;
            tick_q       <= tick_d;
            round_done_q <= round_done_d;
            game_over_q  <= game_over_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    // Compute the FSM transition and every register update for this cycle.
    always_comb begin
        // NOTE: every signal written below gets its hold/default value first,
        // so no branch can leave one unassigned and infer a latch.
        state_d      = state_q;
        secs_d       = secs_q;
        score_d      = score_q;
        round_d      = round_q;
        presc_d      = presc_q;
        start_d      = start;
        pause_d      = pause;
        tick_d       = 1'b0;
        round_done_d = 1'b0;
        game_over_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                secs_d  = SECS_INIT;
                presc_d = '0;
                state_d = S_RUN;
            end

            S_RUN: begin
                // A hit in the final-tick cycle still scores.
                if (hit) begin
                    score_d = bcd_inc_sat(score_q);
                end
                if (presc_last) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    secs_d  = bcd_dec(secs_q);
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
                // The final tick outranks a simultaneous pause press.
                if (final_tick) begin
                    state_d = S_TIMEOUT;
                end else if (pause_rise) begin
                    state_d = S_PAUSE;
                end
            end

            S_PAUSE: begin
                // Prescaler and seconds stay frozen; start and hit are ignored.
                if (pause_rise) begin
                    state_d = S_RUN;
                end
            end

            S_TIMEOUT: begin
                if (round_q == ROUND_LAST) begin
                    state_d = S_OVER;
                end else begin
                    round_d = round_q + 4'd1;
`ifdef GAME_ROUND_AUTO_ADVANCE_EN
                    state_d = S_LOAD;
`else
                    state_d = S_GAP;
`endif
                end
            end

            S_GAP: begin
                if (start_rise) begin
                    state_d = S_LOAD;
                end
            end

            S_OVER: begin
                if (start_rise) begin
                    state_d = S_IDLE;
                    score_d = 8'h00;
                    round_d = 4'd1;
                    secs_d  = SECS_INIT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of the state being entered,
        // which keeps them aligned with the state port.
        round_done_d = (state_d == S_TIMEOUT);
        game_over_d  = (state_d == S_OVER);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign disp_val   = {secs_q, score_q};
    assign round      = round_q;
    assign state      = state_q;
    assign tick       = tick_q;
    assign round_done = round_done_q;
    assign game_over  = game_over_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    secs_is_bcd_a: assert property (@(posedge clk) disable iff (rst)
        (secs_q[3:0] <= 4'd9) && (secs_q[7:4] <= 4'd9));

    score_is_bcd_a: assert property (@(posedge clk) disable iff (rst)
        (score_q[3:0] <= 4'd9) && (score_q[7:4] <= 4'd9));

    round_in_range_a: assert property (@(posedge clk) disable iff (rst)
        (round_q >= 4'd1) && (round_q <= ROUND_LAST));

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl. Three instances with different
// parameter sets share the same stimulus; a cycle-level behavioural model of
// each, written with plain integer seconds and score, tracks the expected
// outputs for the randomized phase, while the directed scenarios check fixed
// expected values.
module tb_game_round_ctrl;

    localparam int N = 3;

    localparam int M_IDLE    = 0;
    localparam int M_LOAD    = 1;
    localparam int M_RUN     = 2;
    localparam int M_PAUSE   = 3;
    localparam int M_TIMEOUT = 4;
    localparam int M_GAP     = 5;
    localparam int M_OVER    = 6;

    logic clk = 1'b0;
    logic rst, start, pause, hit;

    logic [15:0] disp_a, disp_b, disp_c;
    logic [3:0]  round_a, round_b, round_c;
    logic [2:0]  state_a, state_b, state_c;
    logic        tick_a, tick_b, tick_c;
    logic        rd_a, rd_b, rd_c;
    logic        go_a, go_b, go_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Instance A: the main test-plan configuration.
    game_round_ctrl #(.TICK_DIV(4), .ROUND_SECS(3), .MAX_ROUNDS(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .hit(hit),
        .disp_val(disp_a), .round(round_a), .state(state_a), .tick(tick_a),
        .round_done(rd_a), .game_over(go_a)
    );

    // Instance B: two-digit countdown exercises the BCD borrow.
    game_round_ctrl #(.TICK_DIV(4), .ROUND_SECS(10), .MAX_ROUNDS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .hit(hit),
        .disp_val(disp_b), .round(round_b), .state(state_b), .tick(tick_b),
        .round_done(rd_b), .game_over(go_b)
    );

    // Instance C: long single round, minimum divider, for score saturation.
    game_round_ctrl #(.TICK_DIV(2), .ROUND_SECS(99), .MAX_ROUNDS(1)) dut_c (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .hit(hit),
        .disp_val(disp_c), .round(round_c), .state(state_c), .tick(tick_c),
        .round_done(rd_c), .game_over(go_c)
    );

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        int mode;
        int secs;
        int score;
        int rnd;
        int presc;
        bit sp;
        bit pp;
        bit tick;
        bit rd;
        bit go;
    } mdl_t;

    mdl_t mdl [N];

    function automatic int td_of(int i);
        case (i)
            0:       return 4;
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int rs_of(int i);
        case (i)
            0:       return 3;
            1:       return 10;
            default: return 99;
        endcase
    endfunction

    function automatic int mr_of(int i);
        case (i)
            0:       return 2;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic mdl_t model_step(mdl_t c, int td, int rs, int mr,
                                        bit r, bit s, bit p, bit h);
        mdl_t n;
        bit   s_rise;
        bit   p_rise;
        if (r) begin
            n.mode = M_IDLE; n.secs = rs; n.score = 0; n.rnd = 1; n.presc = 0;
            n.sp = 1'b1; n.pp = 1'b1; n.tick = 1'b0; n.rd = 1'b0; n.go = 1'b0;
            return n;
        end
        n      = c;
        s_rise = s && !c.sp;
        p_rise = p && !c.pp;
        n.sp   = s;
        n.pp   = p;
        n.tick = 1'b0;
        case (c.mode)
            M_IDLE:  if (s_rise) n.mode = M_LOAD;
            M_LOAD: begin
                n.secs  = rs;
                n.presc = 0;
                n.mode  = M_RUN;
            end
            M_RUN: begin
                if (h && c.score < 99) n.score = c.score + 1;
                if (c.presc == td - 1) begin
                    n.presc = 0;
                    n.tick  = 1'b1;
                    n.secs  = c.secs - 1;
                end else begin
                    n.presc = c.presc + 1;
                end
                if (n.tick && n.secs == 0) n.mode = M_TIMEOUT;
                else if (p_rise)           n.mode = M_PAUSE;
            end
            M_PAUSE: if (p_rise) n.mode = M_RUN;
            M_TIMEOUT: begin
                if (c.rnd == mr) begin
                    n.mode = M_OVER;
                end else begin
                    n.rnd = c.rnd + 1;
`ifdef GAME_ROUND_AUTO_ADVANCE_EN
                    n.mode = M_LOAD;
`else
                    n.mode = M_GAP;
`endif
                end
            end
            M_GAP: if (s_rise) n.mode = M_LOAD;
            M_OVER: begin
                if (s_rise) begin
                    n.mode  = M_IDLE;
                    n.score = 0;
                    n.rnd   = 1;
                    n.secs  = rs;
                end
            end
            default: n.mode = M_IDLE;
        endcase
        n.rd = (n.mode == M_TIMEOUT);
        n.go = (n.mode == M_OVER);
        return n;
    endfunction

    // Expected output vector {disp, round, state, tick, round_done, game_over}.
    function automatic logic [25:0] expv(mdl_t c);
        logic [15:0] d;
        d = {4'(c.secs / 10), 4'(c.secs % 10), 4'(c.score / 10), 4'(c.score % 10)};
        return {d, 4'(c.rnd), 3'(c.mode), c.tick, c.rd, c.go};
    endfunction

    function automatic logic [25:0] obs(int i);
        case (i)
            0:       return {disp_a, round_a, state_a, tick_a, rd_a, go_a};
            1:       return {disp_b, round_b, state_b, tick_b, rd_b, go_b};
            default: return {disp_c, round_c, state_c, tick_c, rd_c, go_c};
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------
    // One clock: the model consumes the same inputs the DUTs see at the edge;
    // outputs are then observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            mdl[i] = model_step(mdl[i], td_of(i), rs_of(i), mr_of(i), rst, start, pause, hit);
        end
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0; pause = 1'b0; hit = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // start pulse: rise sampled at the first edge (LOAD), then RUN.
    task automatic press_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pause = 1'b0; hit = 1'b0;
        step();
        step();
        tests++; if (state_a !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state_a); end
        tests++; if (round_a !== 4'd1) begin fails++; $display("FAIL reset_round: got %0d expected 1", round_a); end
        tests++; if (disp_a !== 16'h0300) begin fails++; $display("FAIL reset_disp_a: got %h expected 0300", disp_a); end
        tests++; if (disp_b !== 16'h1000) begin fails++; $display("FAIL reset_disp_b: got %h expected 1000", disp_b); end
        tests++; if (disp_c !== 16'h9900) begin fails++; $display("FAIL reset_disp_c: got %h expected 9900", disp_c); end
        tests++; if ({tick_a, rd_a, go_a} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b expected 000", {tick_a, rd_a, go_a}); end
        rst = 1'b0;
        step();
        tests++; if (state_a !== 3'd0) begin fails++; $display("FAIL reset_idle_hold: got %0d expected 0", state_a); end
    endtask

    task automatic test_round_flow();
        logic [7:0] exp_secs;
        do_reset();
        press_start();
        tests++; if (state_a !== 3'd1) begin fails++; $display("FAIL flow_load: state got %0d expected 1", state_a); end
        step();
        tests++; if (state_a !== 3'd2) begin fails++; $display("FAIL flow_run: state got %0d expected 2", state_a); end
        tests++; if (disp_a[15:8] !== 8'h03) begin fails++; $display("FAIL flow_secs03: got %h expected 03", disp_a[15:8]); end
        for (int k = 1; k <= 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                step();
                tests++; if (tick_a !== 1'b0) begin fails++; $display("FAIL flow_no_tick: sec %0d cycle %0d got %b expected 0", k, j, tick_a); end
            end
            step();
            exp_secs = 8'(3 - k);
            tests++; if (tick_a !== 1'b1) begin fails++; $display("FAIL flow_tick: sec %0d got %b expected 1", k, tick_a); end
            tests++; if (disp_a[15:8] !== exp_secs) begin fails++; $display("FAIL flow_secs: got %h expected %h", disp_a[15:8], exp_secs); end
        end
        tests++; if (state_a !== 3'd4) begin fails++; $display("FAIL flow_timeout: state got %0d expected 4", state_a); end
        tests++; if (rd_a !== 1'b1) begin fails++; $display("FAIL flow_round_done: got %b expected 1", rd_a); end
        step();
        tests++; if (rd_a !== 1'b0) begin fails++; $display("FAIL flow_round_done_pulse: got %b expected 0", rd_a); end
        tests++; if (round_a !== 4'd2) begin fails++; $display("FAIL flow_round2: got %0d expected 2", round_a); end
`ifdef GAME_ROUND_AUTO_ADVANCE_EN
        tests++; if (state_a !== 3'd1) begin fails++; $display("FAIL flow_auto_load: state got %0d expected 1", state_a); end
`else
        tests++; if (state_a !== 3'd5) begin fails++; $display("FAIL flow_gap: state got %0d expected 5", state_a); end
        tests++; if (disp_a[15:8] !== 8'h00) begin fails++; $display("FAIL flow_gap_secs: got %h expected 00", disp_a[15:8]); end
`endif
    endtask

    task automatic test_bcd_borrow();
        do_reset();
        press_start();
        step();
        tests++; if (disp_b[15:8] !== 8'h10) begin fails++; $display("FAIL borrow_start: got %h expected 10", disp_b[15:8]); end
        repeat (3) step();
        step();
        tests++; if (tick_b !== 1'b1) begin fails++; $display("FAIL borrow_tick: got %b expected 1", tick_b); end
        tests++; if (disp_b[15:8] !== 8'h09) begin fails++; $display("FAIL borrow_secs: got %h expected 09", disp_b[15:8]); end
    endtask

    task automatic test_pause();
        do_reset();
        press_start();
        step();          // RUN, prescaler 0
        step();          // prescaler 1
        pause = 1'b1;
        step();          // prescaler 2, enter PAUSE
        tests++; if (state_a !== 3'd3) begin fails++; $display("FAIL pause_enter: state got %0d expected 3", state_a); end
        for (int j = 0; j < 20; j++) begin
            hit   = j[0];
            start = (j % 4) < 2;
            step();
            tests++; if ({state_a, disp_a} !== {3'd3, 16'h0300}) begin fails++; $display("FAIL pause_frozen: cycle %0d state %0d disp %h expected 3 0300", j, state_a, disp_a); end
        end
        hit = 1'b0; start = 1'b0; pause = 1'b0;
        step();
        pause = 1'b1;
        step();
        tests++; if (state_a !== 3'd2) begin fails++; $display("FAIL pause_resume: state got %0d expected 2", state_a); end
        pause = 1'b0;
        step();
        tests++; if (tick_a !== 1'b0) begin fails++; $display("FAIL pause_early_tick: got %b expected 0", tick_a); end
        step();
        tests++; if (tick_a !== 1'b1) begin fails++; $display("FAIL pause_resume_tick: got %b expected 1", tick_a); end
        tests++; if (disp_a !== 16'h0200) begin fails++; $display("FAIL pause_after_tick: got %h expected 0200", disp_a); end
    endtask

    task automatic test_scoring();
        do_reset();
        press_start();
        step();
        hit = 1'b1;
        repeat (3) step();
        hit = 1'b0;
        tests++; if (disp_a[7:0] !== 8'h03) begin fails++; $display("FAIL score_r1: got %h expected 03", disp_a[7:0]); end
`ifdef GAME_ROUND_AUTO_ADVANCE_EN
        for (int k = 0; k < 40 && !(state_a === 3'd2 && round_a === 4'd2); k++) step();
        tests++; if ({state_a, round_a} !== {3'd2, 4'd2}) begin fails++; $display("FAIL score_auto_r2: state %0d round %0d expected 2 2", state_a, round_a); end
`else
        for (int k = 0; k < 40 && state_a !== 3'd5; k++) step();
        tests++; if ({state_a, round_a} !== {3'd5, 4'd2}) begin fails++; $display("FAIL score_gap: state %0d round %0d expected 5 2", state_a, round_a); end
        press_start();
        step();
`endif
        hit = 1'b1;
        repeat (2) step();
        hit = 1'b0;
        for (int k = 0; k < 40 && state_a !== 3'd6; k++) step();
        tests++; if (state_a !== 3'd6) begin fails++; $display("FAIL score_over_state: got %0d expected 6", state_a); end
        tests++; if (go_a !== 1'b1) begin fails++; $display("FAIL score_game_over: got %b expected 1", go_a); end
        tests++; if (disp_a[7:0] !== 8'h05) begin fails++; $display("FAIL score_total: got %h expected 05", disp_a[7:0]); end
        press_start();
        tests++; if ({state_a, round_a, disp_a, go_a} !== {3'd0, 4'd1, 16'h0300, 1'b0}) begin
            fails++; $display("FAIL score_restart: state %0d round %0d disp %h go %b expected 0 1 0300 0", state_a, round_a, disp_a, go_a);
        end
    endtask

    task automatic test_final_tick_hit();
        do_reset();
        press_start();
        step();            // RUN, secs 3, prescaler 0
        repeat (11) step();
        tests++; if ({state_a, disp_a} !== {3'd2, 16'h0100}) begin fails++; $display("FAIL final_pre: state %0d disp %h expected 2 0100", state_a, disp_a); end
        hit = 1'b1;
        step();
        hit = 1'b0;
        tests++; if ({state_a, disp_a, tick_a, rd_a} !== {3'd4, 16'h0001, 1'b1, 1'b1}) begin
            fails++; $display("FAIL final_hit: state %0d disp %h tick %b rd %b expected 4 0001 1 1", state_a, disp_a, tick_a, rd_a);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        press_start();
        step();            // C in RUN, secs 99
        hit = 1'b1;
        repeat (98) step();
        tests++; if (disp_c !== 16'h5098) begin fails++; $display("FAIL sat_98: got %h expected 5098", disp_c); end
        repeat (3) step();
        hit = 1'b0;
        tests++; if (disp_c[7:0] !== 8'h99) begin fails++; $display("FAIL sat_99: got %h expected 99", disp_c[7:0]); end
        tests++; if (state_c !== 3'd2) begin fails++; $display("FAIL sat_state: got %0d expected 2", state_c); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press_start();
        step();
        pause = 1'b1;
        step();
        tests++; if (state_a !== 3'd3) begin fails++; $display("FAIL rstmid_pause: state got %0d expected 3", state_a); end
        start = 1'b1;
        rst   = 1'b1;
        step();
        tests++; if ({state_a, round_a, disp_a, tick_a, rd_a, go_a} !== {3'd0, 4'd1, 16'h0300, 3'b000}) begin
            fails++; $display("FAIL rstmid_values: state %0d round %0d disp %h pulses %b expected 0 1 0300 000", state_a, round_a, disp_a, {tick_a, rd_a, go_a});
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            tests++; if (state_a !== 3'd0) begin fails++; $display("FAIL rstmid_held_start: cycle %0d state %0d expected 0", k, state_a); end
        end
        start = 1'b0;
        pause = 1'b0;
        step();
        press_start();
        tests++; if (state_a !== 3'd1) begin fails++; $display("FAIL rstmid_repress: state got %0d expected 1", state_a); end
        step();
    endtask

    task automatic test_random();
        logic [25:0] o;
        logic        nib_ok;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom % 300) == 0;
            if (($urandom % 6) == 0)  start = ~start;
            if (($urandom % 25) == 0) pause = ~pause;
            hit = ($urandom % 3) == 0;
            step();
            for (int i = 0; i < N; i++) begin
                o = obs(i);
                tests++;
                if (o !== expv(mdl[i])) begin
                    fails++;
                    $display("FAIL random_model: inst %0d cycle %0d dut %h model %h", i, c, o, expv(mdl[i]));
                end
                nib_ok = (o[25:22] <= 4'd9) && (o[21:18] <= 4'd9) && (o[17:14] <= 4'd9) && (o[13:10] <= 4'd9);
                tests++;
                if (nib_ok !== 1'b1) begin
                    fails++;
                    $display("FAIL random_bcd: inst %0d cycle %0d disp %h has a non-BCD nibble", i, c, o[25:10]);
                end
            end
        end
        rst = 1'b0; start = 1'b0; pause = 1'b0; hit = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; hit = 1'b0;
        test_reset();
        test_round_flow();
        test_bcd_borrow();
        test_pause();
        test_scoring();
        test_final_tick_hit();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
